// File: rtl/mem_arbiter.sv
// Byte-serial external memory/IO port shared by the icache (word fetches) and the
// load/store buffer. One transaction in flight; round-robin between the two on a tie.
module mem_arbiter #(
  parameter int         ADDR_W    = 32,
  parameter logic [1:0] IO_PREFIX = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_all,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_grant,
  output logic              icache_done,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [2:0]        lsb_width,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_grant,
  output logic              lsb_done,
  output logic [31:0]       rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_RWAIT, S_WR} state_e;

  typedef struct packed {
    logic            is_lsb;
    logic [2:0]      width;
    logic [3:0][7:0] wdata;
  } req_t;

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic                last_lsb_q, last_lsb_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic                cap_en_q, cap_en_d;
  logic [1:0]          cap_idx_q, cap_idx_d;
  logic [3:0][7:0]     buf_q, buf_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                wr_q, wr_d;
  logic                ic_grant_q, ic_grant_d, lsb_grant_q, lsb_grant_d;
  logic                ic_done_q, ic_done_d, lsb_done_q, lsb_done_d;
  logic [31:0]         rdata_q, rdata_d;

  logic lsb_elig, pick_lsb, accept;

  function automatic logic [1:0] last_of(input logic is_lsb, input logic [2:0] w);
    if (!is_lsb) return 2'd3;
    case (w)
      3'b010:         return 2'd3;
      3'b001, 3'b101: return 2'd1;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic is_lsb, input logic [2:0] w,
                                         input logic [3:0][7:0] b);
    logic [31:0] r;
    r = b;
    if (is_lsb) begin
      case (w)
        3'b000:  r = {{24{b[0][7]}}, b[0]};
        3'b001:  r = {{16{b[1][7]}}, b[1], b[0]};
        3'b100:  r = {24'h0, b[0]};
        3'b101:  r = {16'h0, b[1], b[0]};
        default: r = b;
      endcase
    end
    return r;
  endfunction

  // IO stores wait out a full UART buffer; loads and icache fetches are never blocked.
  assign lsb_elig = lsb_req &&
                    !(lsb_wr && (lsb_addr[17:16] == IO_PREFIX) && io_buffer_full);
  assign pick_lsb = lsb_elig && (!icache_req || !last_lsb_q);
  assign accept   = (state_q == S_IDLE) && !clear_all && (icache_req || lsb_elig);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    last_lsb_d  = last_lsb_q;
    idx_d       = idx_q;
    last_d      = last_q;
    cap_en_d    = 1'b0;
    cap_idx_d   = cap_idx_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    wr_d        = wr_q;
    ic_grant_d  = 1'b0;
    lsb_grant_d = 1'b0;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    rdata_d     = rdata_q;

    // Byte issued last cycle is on mem_din now.
    if (cap_en_q) buf_d[cap_idx_q] = mem_din;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_lsb_d   = pick_lsb;
          req_d.is_lsb = pick_lsb;
          req_d.width  = pick_lsb ? lsb_width : 3'b010;
          req_d.wdata  = lsb_wdata;
          idx_d        = 2'd0;
          last_d       = last_of(pick_lsb, lsb_width);
          mem_a_d      = pick_lsb ? lsb_addr : icache_addr;
          ic_grant_d   = !pick_lsb;
          lsb_grant_d  = pick_lsb;
          if (pick_lsb && lsb_wr) begin
            state_d    = S_WR;
            wr_d       = 1'b1;
            mem_dout_d = lsb_wdata[7:0];
          end else begin
            state_d    = S_RD;
          end
        end
      end
      S_RD: begin
        if (clear_all) begin
          state_d = S_IDLE;
        end else begin
          cap_en_d  = 1'b1;
          cap_idx_d = idx_q;
          if (idx_q == last_q) begin
            state_d = S_RWAIT;
          end else begin
            idx_d   = idx_q + 2'd1;
            mem_a_d = mem_a_q + ADDR_W'(1);
          end
        end
      end
      S_RWAIT: begin
        state_d = S_IDLE;
        if (!clear_all) begin
          rdata_d = extend(req_q.is_lsb, req_q.width, buf_d);
          if (req_q.is_lsb) lsb_done_d = 1'b1;
          else              ic_done_d  = 1'b1;
        end
      end
      S_WR: begin
        // A committed store always completes, flush or not.
        if (idx_q == last_q) begin
          state_d    = S_IDLE;
          wr_d       = 1'b0;
          lsb_done_d = 1'b1;
        end else begin
          idx_d      = idx_q + 2'd1;
          mem_a_d    = mem_a_q + ADDR_W'(1);
          mem_dout_d = req_q.wdata[idx_q + 2'd1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      last_lsb_q  <= 1'b0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= 2'd0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= 8'h0;
      wr_q        <= 1'b0;
      ic_grant_q  <= 1'b0;
      lsb_grant_q <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      rdata_q     <= 32'h0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      req_q       <= req_d;
      last_lsb_q  <= last_lsb_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cap_en_q    <= cap_en_d;
      cap_idx_q   <= cap_idx_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      wr_q        <= wr_d;
      ic_grant_q  <= ic_grant_d;
      lsb_grant_q <= lsb_grant_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      rdata_q     <= rdata_d;
    end
  end

  // Gating with rdy_in keeps a frozen write cycle from hitting memory twice.
  assign mem_wr       = wr_q & rdy_in;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign icache_grant = ic_grant_q;
  assign lsb_grant    = lsb_grant_q;
  assign icache_done  = ic_done_q;
  assign lsb_done     = lsb_done_q;
  assign rdata        = rdata_q;

endmodule
